// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI host FIFO bridge.
package spi_bridge_pkg;

    localparam logic [15:0] SPI_IDLE_WORD = 16'hFFFF;

    typedef logic [15:0] spi_word_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } ack_state_t;

endpackage

// File: rtl/spi_host_fifo_bridge_sync_fifo.sv
// Show-ahead synchronous FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable; a push on a full FIFO succeeds when a pop
// happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rptr[AW-1:0]];

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + ONE;
            if (do_pop)  rptr <= rptr + ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_host_fifo_bridge.sv
// Host-side bridge for a 16-bit SPI slave: acknowledges received words into
// an RX FIFO and feeds the slave's next transmit word from a TX FIFO.
// Optional macro SPI_BRIDGE_LOOPBACK_EN adds a loopback_en port that copies
// every received word into the TX FIFO.
module spi_host_fifo_bridge
    import spi_bridge_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     reset,
`ifdef SPI_BRIDGE_LOOPBACK_EN
    input  logic                     loopback_en,
`endif
    input  logic [WIDTH-1:0]         slv_dat_i,
    input  logic                     slv_wr_req,
    output logic                     slv_wr_req_ack,
    output logic [WIDTH-1:0]         slv_dat_o,
    input  logic                     slv_busy,
    output logic [WIDTH-1:0]         rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    input  logic [WIDTH-1:0]         tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     rx_overflow,
    output logic                     tx_underrun,
    input  logic                     clear_err
);
    ack_state_t       state;
    ack_state_t       state_next;
    logic             complete;

    logic             rx_full;
    logic             rx_empty;
    logic             rx_pop;

    logic             tx_full;
    logic             tx_empty;
    logic             tx_push;
    logic [WIDTH-1:0] tx_push_data;
    logic             tx_pop;
    logic [WIDTH-1:0] tx_head;
    logic [$clog2(DEPTH):0] tx_count;

    spi_word_t        held_word;
    logic             held_valid;

    // A transaction completes when a fresh request is seen in IDLE.
    assign complete = (state == IDLE) && slv_wr_req;

    // ---------------- RX path ----------------
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_ready && rx_valid;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx_fifo (
        .clk_i     (clk_i),
        .reset     (reset),
        .push      (complete),
        .push_data (slv_dat_i),
        .pop       (rx_pop),
        .pop_data  (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // ---------------- TX path ----------------
`ifdef SPI_BRIDGE_LOOPBACK_EN
    logic lb_push;
    assign lb_push      = loopback_en && complete;
    assign tx_ready     = !tx_full && !lb_push;
    assign tx_push      = lb_push || (tx_valid && tx_ready);
    assign tx_push_data = lb_push ? slv_dat_i : tx_data;
`else
    assign tx_ready     = !tx_full;
    assign tx_push      = tx_valid && tx_ready;
    assign tx_push_data = tx_data;
`endif

    // Refill the holding register at completion, or early while the slave is idle.
    assign tx_pop = !tx_empty && (complete || (!held_valid && !slv_busy));

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx_fifo (
        .clk_i     (clk_i),
        .reset     (reset),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    assign slv_dat_o = held_word;

    // ---------------- Acknowledge FSM ----------------
    // State register plus registered ack pulse.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state          <= IDLE;
            slv_wr_req_ack <= 1'b0;
        end else begin
            state          <= state_next;
            slv_wr_req_ack <= (state_next == ACK);
        end
    end

    // Next-state logic: wait for the request to drop so it is acked once.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (slv_wr_req) state_next = ACK;
            ACK:      state_next = WAIT_LOW;
            WAIT_LOW: if (!slv_wr_req) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // TX holding register: only changes at completion or while the slave is idle.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            held_word  <= SPI_IDLE_WORD;
            held_valid <= 1'b0;
        end else if (complete) begin
            if (!tx_empty) begin
                held_word  <= tx_head;
                held_valid <= 1'b1;
            end else begin
                held_word  <= SPI_IDLE_WORD;
                held_valid <= 1'b0;
            end
        end else if (tx_pop) begin
            held_word  <= tx_head;
            held_valid <= 1'b1;
        end
    end

    // Sticky error flags; a set in the same cycle as clear_err wins.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (complete && rx_full && !rx_pop) rx_overflow <= 1'b1;
            else if (clear_err)                 rx_overflow <= 1'b0;
            if (complete && !held_valid)        tx_underrun <= 1'b1;
            else if (clear_err)                 tx_underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_host_fifo_bridge.sv
// Directed self-checking bench for spi_host_fifo_bridge.
module tb_spi_host_fifo_bridge;

    logic        clk_i = 1'b0;
    logic        reset = 1'b1;
`ifdef SPI_BRIDGE_LOOPBACK_EN
    logic        loopback_en = 1'b0;
`endif
    logic [15:0] slv_dat_i = '0;
    logic        slv_wr_req = 1'b0;
    logic        slv_wr_req_ack;
    logic [15:0] slv_dat_o;
    logic        slv_busy = 1'b0;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [3:0]  rx_count;
    logic        rx_overflow;
    logic        tx_underrun;
    logic        clear_err = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    spi_host_fifo_bridge #(.DEPTH(8), .WIDTH(16)) dut (
        .clk_i          (clk_i),
        .reset          (reset),
`ifdef SPI_BRIDGE_LOOPBACK_EN
        .loopback_en    (loopback_en),
`endif
        .slv_dat_i      (slv_dat_i),
        .slv_wr_req     (slv_wr_req),
        .slv_wr_req_ack (slv_wr_req_ack),
        .slv_dat_o      (slv_dat_o),
        .slv_busy       (slv_busy),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_count       (rx_count),
        .rx_overflow    (rx_overflow),
        .tx_underrun    (tx_underrun),
        .clear_err      (clear_err)
    );

    always #5 clk_i = ~clk_i;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Slave-side handshake: raise request, drop it when ack is seen.
    task automatic do_req(input logic [15:0] w);
        slv_dat_i  = w;
        slv_wr_req = 1'b1;
        tick(1);
        slv_wr_req = 1'b0;
        tick(2);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
    endtask

    task automatic pop_rx();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        n_tests++; if (slv_wr_req_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", slv_wr_req_ack); end
        n_tests++; if (slv_dat_o !== 16'hFFFF) begin n_fail++; $display("FAIL reset_dat_o: got %h want ffff", slv_dat_o); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_tests++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL reset_rx_count: got %0d want 0", rx_count); end
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        n_tests++; if (rx_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_rx_overflow: got %b want 0", rx_overflow); end
        n_tests++; if (tx_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_tx_underrun: got %b want 0", tx_underrun); end
    endtask

    task automatic test_single_word();
        n_tests++; if (slv_wr_req_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_before: got %b want 0", slv_wr_req_ack); end
        slv_dat_i  = 16'hA5C3;
        slv_wr_req = 1'b1;
        tick(1);
        n_tests++; if (slv_wr_req_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack_pulse: got %b want 1", slv_wr_req_ack); end
        slv_wr_req = 1'b0;
        tick(1);
        n_tests++; if (slv_wr_req_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_drop: got %b want 0", slv_wr_req_ack); end
        tick(1);
        n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL single_rx_valid: got %b want 1", rx_valid); end
        n_tests++; if (rx_data !== 16'hA5C3) begin n_fail++; $display("FAIL single_rx_data: got %h want a5c3", rx_data); end
        n_tests++; if (rx_count !== 4'd1) begin n_fail++; $display("FAIL single_rx_count: got %0d want 1", rx_count); end
        // Request already low: no second acknowledge.
        n_tests++; if (slv_wr_req_ack !== 1'b0) begin n_fail++; $display("FAIL single_no_reack: got %b want 0", slv_wr_req_ack); end
        pop_rx();
        n_tests++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL single_pop_count: got %0d want 0", rx_count); end
        pulse_clear();
    endtask

    task automatic test_rx_overflow();
        logic [15:0] exp;
        for (int i = 0; i < 9; i++) do_req(16'h1000 + 16'(i));
        n_tests++; if (rx_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d want 8", rx_count); end
        n_tests++; if (rx_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", rx_overflow); end
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_tx_ready: got %b want 1", tx_ready); end
        for (int i = 0; i < 8; i++) begin
            exp = 16'h1000 + 16'(i);
            n_tests++; if (rx_data !== exp) begin n_fail++; $display("FAIL ovf_readback%0d: got %h want %h", i, rx_data, exp); end
            pop_rx();
        end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b want 0", rx_valid); end
        n_tests++; if (rx_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", rx_overflow); end
        pulse_clear();
        n_tests++; if (rx_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", rx_overflow); end
        n_tests++; if (tx_underrun !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_unr: got %b want 0", tx_underrun); end
    endtask

    task automatic test_tx_seq();
        tx_valid = 1'b1;
        tx_data  = 16'h1111;
        tick(1);
        tx_data  = 16'h2222;
        tick(1);
        tx_valid = 1'b0;
        tick(1);
        n_tests++; if (slv_dat_o !== 16'h1111) begin n_fail++; $display("FAIL tx_first: got %h want 1111", slv_dat_o); end
        do_req(16'h0001);
        n_tests++; if (slv_dat_o !== 16'h2222) begin n_fail++; $display("FAIL tx_second: got %h want 2222", slv_dat_o); end
        do_req(16'h0002);
        n_tests++; if (slv_dat_o !== 16'hFFFF) begin n_fail++; $display("FAIL tx_idle: got %h want ffff", slv_dat_o); end
        n_tests++; if (tx_underrun !== 1'b0) begin n_fail++; $display("FAIL tx_no_underrun: got %b want 0", tx_underrun); end
        do_req(16'h0003);
        n_tests++; if (tx_underrun !== 1'b1) begin n_fail++; $display("FAIL tx_underrun: got %b want 1", tx_underrun); end
        for (int i = 0; i < 3; i++) pop_rx();
        n_tests++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL tx_rx_drain: got %0d want 0", rx_count); end
        pulse_clear();
    endtask

    task automatic test_busy_hold();
        slv_busy = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 16'hABCD;
        tick(1);
        tx_valid = 1'b0;
        tick(4);
        n_tests++; if (slv_dat_o !== 16'hFFFF) begin n_fail++; $display("FAIL busy_hold: got %h want ffff", slv_dat_o); end
        slv_busy = 1'b0;
        tick(2);
        n_tests++; if (slv_dat_o !== 16'hABCD) begin n_fail++; $display("FAIL busy_load: got %h want abcd", slv_dat_o); end
    endtask

    task automatic test_full_boundary();
        logic [15:0] exp;
        for (int i = 0; i < 8; i++) do_req(16'h2000 + 16'(i));
        pulse_clear();
        n_tests++; if (rx_count !== 4'd8) begin n_fail++; $display("FAIL full_count_pre: got %0d want 8", rx_count); end
        slv_dat_i  = 16'h7777;
        slv_wr_req = 1'b1;
        rx_ready   = 1'b1;
        tick(1);
        rx_ready   = 1'b0;
        slv_wr_req = 1'b0;
        n_tests++; if (slv_wr_req_ack !== 1'b1) begin n_fail++; $display("FAIL full_ack: got %b want 1", slv_wr_req_ack); end
        n_tests++; if (rx_count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", rx_count); end
        n_tests++; if (rx_overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got %b want 0", rx_overflow); end
        tick(2);
        for (int i = 1; i < 9; i++) begin
            exp = (i == 8) ? 16'h7777 : 16'h2000 + 16'(i);
            n_tests++; if (rx_data !== exp) begin n_fail++; $display("FAIL full_readback%0d: got %h want %h", i, rx_data, exp); end
            pop_rx();
        end
        pulse_clear();
    endtask

    task automatic test_reset_mid();
`ifdef SPI_BRIDGE_LOOPBACK_EN
        loopback_en = 1'b1;
`endif
        slv_dat_i  = 16'h5A5A;
        slv_wr_req = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_tests++; if (slv_wr_req_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_ack: got %b want 0", slv_wr_req_ack); end
        n_tests++; if (slv_dat_o !== 16'hFFFF) begin n_fail++; $display("FAIL rmid_dat_o: got %h want ffff", slv_dat_o); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rx_valid: got %b want 0", rx_valid); end
        n_tests++; if (rx_count !== 4'd0) begin n_fail++; $display("FAIL rmid_rx_count: got %0d want 0", rx_count); end
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_tx_ready: got %b want 1", tx_ready); end
        n_tests++; if (tx_underrun !== 1'b0) begin n_fail++; $display("FAIL rmid_underrun: got %b want 0", tx_underrun); end
        tick(1);
        n_tests++; if (slv_wr_req_ack !== 1'b1) begin n_fail++; $display("FAIL rmid_reack: got %b want 1", slv_wr_req_ack); end
        n_tests++; if (rx_count !== 4'd1) begin n_fail++; $display("FAIL rmid_count: got %0d want 1", rx_count); end
        slv_wr_req = 1'b0;
        tick(2);
        n_tests++; if (rx_data !== 16'h5A5A) begin n_fail++; $display("FAIL rmid_rx_data: got %h want 5a5a", rx_data); end
`ifdef SPI_BRIDGE_LOOPBACK_EN
        n_tests++; if (slv_dat_o !== 16'h5A5A) begin n_fail++; $display("FAIL rmid_loopback: got %h want 5a5a", slv_dat_o); end
        loopback_en = 1'b0;
`else
        n_tests++; if (slv_dat_o !== 16'hFFFF) begin n_fail++; $display("FAIL rmid_dat_idle: got %h want ffff", slv_dat_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_rx_overflow();
        test_tx_seq();
        test_busy_hold();
        test_full_boundary();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
